// File: rtl/axi4_sram_slave_if.sv
// AXI4 single-beat bus bundle between the core's master and the SRAM slave.
// Signal names follow the AXI4 channel naming used by the master.
interface axi4_sram_slave_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic        BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic        RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// Single-beat AXI4 slave over a word-wide SRAM; one transaction in flight at a time.
// Define AXI4_SRAM_WAIT_EN to insert READ_WAIT extra read-latency cycles via R_WAIT.
module axi4_sram_slave #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          READ_WAIT = 2
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    axi4_sram_slave_if.slave bus
);
    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_WAIT, R_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
`ifdef AXI4_SRAM_WAIT_EN
    logic [7:0]  wait_cnt_q, wait_cnt_d;
`endif

    logic [31:0]      mem [DEPTH];
    logic [31:0]      w_addr, w_off, r_off, rd_word;
    logic [IDX_W-1:0] w_idx, r_idx;
    logic             w_ok, r_ok, w_hs, ar_hs, mem_we;
    logic             unused_bits;

    assign bus.AWREADY = (state_q == IDLE);
    assign bus.ARREADY = (state_q == IDLE) && !bus.AWVALID;
    assign bus.WREADY  = ((state_q == IDLE) && bus.AWVALID) || (state_q == W_DATA);
    assign bus.BVALID  = (state_q == W_RESP);
    assign bus.BRESP   = bresp_q;
    assign bus.BID     = 1'b0;
    assign bus.RVALID  = (state_q == R_RESP);
    assign bus.RLAST   = (state_q == R_RESP);
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RID     = 1'b0;

    // The write address comes straight off AW when W arrives together with it
    assign w_addr = (state_q == W_DATA) ? addr_q : bus.AWADDR;
    assign w_off  = w_addr - BASE_ADDR;
    assign w_ok   = (w_addr >= BASE_ADDR) && ((w_off >> 2) < 32'(DEPTH));
    assign w_idx  = w_off[IDX_W+1:2];
    assign r_off  = bus.ARADDR - BASE_ADDR;
    assign r_ok   = (bus.ARADDR >= BASE_ADDR) && ((r_off >> 2) < 32'(DEPTH));
    assign r_idx  = r_off[IDX_W+1:2];

    assign w_hs    = bus.WVALID && bus.WREADY;
    assign ar_hs   = bus.ARVALID && bus.ARREADY;
    assign mem_we  = w_hs && w_ok;
    assign rd_word = mem[r_idx];

    assign unused_bits = ^{bus.WLAST, w_off, r_off, 8'(READ_WAIT)};

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.WSTRB[b]) mem[w_idx][8*b +: 8] <= bus.WDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        bresp_d = bresp_q;
        rresp_d = rresp_q;
`ifdef AXI4_SRAM_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.AWVALID) begin
                    if (w_hs) begin
                        bresp_d = w_ok ? RESP_OKAY : RESP_SLVERR;
                        state_d = W_RESP;
                    end else begin
                        addr_d  = bus.AWADDR;
                        state_d = W_DATA;
                    end
                end else if (ar_hs) begin
                    rdata_d = r_ok ? rd_word : 32'h0;
                    rresp_d = r_ok ? RESP_OKAY : RESP_SLVERR;
`ifdef AXI4_SRAM_WAIT_EN
                    if (READ_WAIT == 0) begin
                        state_d = R_RESP;
                    end else begin
                        state_d    = R_WAIT;
                        wait_cnt_d = 8'(READ_WAIT);
                    end
`else
                    state_d = R_RESP;
`endif
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    bresp_d = w_ok ? RESP_OKAY : RESP_SLVERR;
                    state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.BREADY) state_d = IDLE;
            end
            R_WAIT: begin
`ifdef AXI4_SRAM_WAIT_EN
                if (wait_cnt_q <= 8'd1) state_d = R_RESP;
                else                    wait_cnt_d = wait_cnt_q - 8'd1;
`else
                state_d = IDLE;
`endif
            end
            R_RESP: begin
                if (bus.RREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            rdata_q <= 32'h0;
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
`ifdef AXI4_SRAM_WAIT_EN
            wait_cnt_q <= 8'h0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
`ifdef AXI4_SRAM_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: writes, strobes, range errors, arbitration, stalls, resets.
// Build with AXI4_SRAM_WAIT_EN to check the 1+READ_WAIT read latency.
module tb_axi4_sram_slave;
    localparam int TB_READ_WAIT = 3;
`ifdef AXI4_SRAM_WAIT_EN
    localparam int RD_LAT = 1 + TB_READ_WAIT;
`else
    localparam int RD_LAT = 1;
`endif

    logic aclk = 1'b0;
    logic aresetn;
    int   checks = 0;
    int   errors = 0;

    axi4_sram_slave_if bus();

    axi4_sram_slave #(
        .DEPTH    (1024),
        .BASE_ADDR(32'h0),
        .READ_WAIT(TB_READ_WAIT)
    ) dut (
        .ACLK   (aclk),
        .ARESETn(aresetn),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("[TB] %s differs", tag);
        end
    endtask

    // Called and returns on a falling edge; the B handshake is the last rising edge seen
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit together, input logic [1:0] exp_resp);
        int guard;
        int lat;
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        if (together) begin
            bus.WDATA  = data;
            bus.WSTRB  = strb;
            bus.WVALID = 1'b1;
        end
        guard = 0;
        while (!bus.AWREADY && guard < 20) begin
            @(negedge aclk);
            guard++;
        end
        check_output({tag, "_awready"}, 32'(bus.AWREADY), 32'd1);
        @(negedge aclk);
        bus.AWVALID = 1'b0;
        if (!together) begin
            bus.WDATA  = data;
            bus.WSTRB  = strb;
            bus.WVALID = 1'b1;
            @(negedge aclk);
        end
        bus.WVALID = 1'b0;
        lat = 1;
        while (!bus.BVALID && lat < 20) begin
            @(negedge aclk);
            lat++;
        end
        check_output({tag, "_bvalid"}, 32'(bus.BVALID), 32'd1);
        check_output({tag, "_bresp"}, 32'(bus.BRESP), 32'(exp_resp));
        check_output({tag, "_blat"}, 32'(lat), 32'd1);
        bus.BREADY = 1'b1;
        @(negedge aclk);
        bus.BREADY = 1'b0;
        check_output({tag, "_bdone"}, 32'(bus.BVALID), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int hold);
        int guard;
        int lat;
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        guard = 0;
        while (!bus.ARREADY && guard < 20) begin
            @(negedge aclk);
            guard++;
        end
        check_output({tag, "_arready"}, 32'(bus.ARREADY), 32'd1);
        @(negedge aclk);
        bus.ARVALID = 1'b0;
        lat = 1;
        while (!bus.RVALID && lat < 20) begin
            @(negedge aclk);
            lat++;
        end
        check_output({tag, "_rvalid"}, 32'(bus.RVALID), 32'd1);
        check_output({tag, "_rlast"}, 32'(bus.RLAST), 32'd1);
        check_output({tag, "_rdata"}, bus.RDATA, exp_data);
        check_output({tag, "_rresp"}, 32'(bus.RRESP), 32'(exp_resp));
        check_output({tag, "_rlat"}, 32'(lat), 32'(RD_LAT));
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check_output({tag, "_hold_rvalid"}, 32'(bus.RVALID), 32'd1);
            check_output({tag, "_hold_rdata"}, bus.RDATA, exp_data);
            check_output({tag, "_hold_rresp"}, 32'(bus.RRESP), 32'(exp_resp));
        end
        bus.RREADY = 1'b1;
        @(negedge aclk);
        bus.RREADY = 1'b0;
        check_output({tag, "_rdone"}, 32'(bus.RVALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        aresetn     = 1'b0;
        bus.AWADDR  = 32'h0;
        bus.AWVALID = 1'b0;
        bus.WDATA   = 32'h0;
        bus.WSTRB   = 4'h0;
        bus.WLAST   = 1'b1;
        bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b0;
        bus.ARADDR  = 32'h0;
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;

        repeat (2) @(negedge aclk);
        check_output("rst_bvalid", 32'(bus.BVALID), 32'd0);
        check_output("rst_rvalid", 32'(bus.RVALID), 32'd0);
        check_output("rst_rlast", 32'(bus.RLAST), 32'd0);
        check_output("rst_bresp", 32'(bus.BRESP), 32'd0);
        check_output("rst_rresp", 32'(bus.RRESP), 32'd0);
        check_output("rst_rdata", bus.RDATA, 32'h0);
        aresetn = 1'b1;
        @(negedge aclk);
        check_output("idle_awready", 32'(bus.AWREADY), 32'd1);
        check_output("idle_arready", 32'(bus.ARREADY), 32'd1);
        check_output("idle_wready", 32'(bus.WREADY), 32'd0);

        // Full write, then a read issued the cycle after the B handshake
        do_write("t1_wr", 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00);
        do_read("t1_rd", 32'h10, 32'hDEADBEEF, 2'b00, 0);
        do_read("t1_unaligned", 32'h13, 32'hDEADBEEF, 2'b00, 0);

        do_write("t2_wr0", 32'h20, 32'h11223344, 4'hF, 1'b0, 2'b00);
        do_write("t2_wr1", 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, 2'b00);
        do_write("t2_nostrb", 32'h20, 32'hFFFFFFFF, 4'h0, 1'b1, 2'b00);
        do_read("t2_rd", 32'h20, 32'h11BB33DD, 2'b00, 0);

        // Out of range aliases word 0 if decoded wrongly, so word 0 must stay intact
        do_write("t3_wr0", 32'h0, 32'h5A5A5A5A, 4'hF, 1'b1, 2'b00);
        do_write("t3_top", 32'hFFC, 32'h0BADF00D, 4'hF, 1'b0, 2'b00);
        do_write("t3_oor", 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b1, 2'b10);
        do_read("t3_oor_rd", 32'h1000, 32'h0, 2'b10, 0);
        do_read("t3_rd0", 32'h0, 32'h5A5A5A5A, 2'b00, 0);
        do_read("t3_top_rd", 32'hFFC, 32'h0BADF00D, 2'b00, 0);

        bus.AWADDR  = 32'h30;
        bus.AWVALID = 1'b1;
        bus.ARADDR  = 32'h30;
        bus.ARVALID = 1'b1;
        #1;
        check_output("t4_awready", 32'(bus.AWREADY), 32'd1);
        check_output("t4_arready", 32'(bus.ARREADY), 32'd0);
        check_output("t4_wready", 32'(bus.WREADY), 32'd1);
        @(negedge aclk);
        bus.AWVALID = 1'b0;
        #1;
        check_output("t4_wdata_arready", 32'(bus.ARREADY), 32'd0);
        check_output("t4_wdata_wready", 32'(bus.WREADY), 32'd1);
        bus.WDATA  = 32'hCAFEF00D;
        bus.WSTRB  = 4'hF;
        bus.WVALID = 1'b1;
        @(negedge aclk);
        bus.WVALID = 1'b0;
        check_output("t4_bvalid", 32'(bus.BVALID), 32'd1);
        check_output("t4_bresp", 32'(bus.BRESP), 32'd0);
        check_output("t4_bresp_arready", 32'(bus.ARREADY), 32'd0);
        bus.BREADY = 1'b1;
        @(negedge aclk);
        bus.BREADY = 1'b0;
        check_output("t4_after_b_arready", 32'(bus.ARREADY), 32'd1);
        @(negedge aclk);
        bus.ARVALID = 1'b0;
        lat = 1;
        while (!bus.RVALID && lat < 20) begin
            @(negedge aclk);
            lat++;
        end
        check_output("t4_rlat", 32'(lat), 32'(RD_LAT));
        check_output("t4_rdata", bus.RDATA, 32'hCAFEF00D);
        bus.RREADY = 1'b1;
        @(negedge aclk);
        bus.RREADY = 1'b0;

        do_read("t5_stall", 32'h20, 32'h11BB33DD, 2'b00, 5);

        // Reset while in W_DATA: the pending write must never land
        do_write("t5_wr40", 32'h40, 32'h01234567, 4'hF, 1'b1, 2'b00);
        bus.AWADDR  = 32'h40;
        bus.AWVALID = 1'b1;
        @(negedge aclk);
        bus.AWVALID = 1'b0;
        #1;
        check_output("t5_wdata_state", 32'(bus.WREADY), 32'd1);
        aresetn = 1'b0;
        #1;
        check_output("t5_rst_bvalid", 32'(bus.BVALID), 32'd0);
        check_output("t5_rst_wready", 32'(bus.WREADY), 32'd0);
        @(negedge aclk);
        aresetn    = 1'b1;
        bus.WDATA  = 32'hFFFFFFFF;
        bus.WSTRB  = 4'hF;
        bus.WVALID = 1'b1;
        @(negedge aclk);
        check_output("t5_post_bvalid", 32'(bus.BVALID), 32'd0);
        check_output("t5_post_wready", 32'(bus.WREADY), 32'd0);
        bus.WVALID = 1'b0;
        @(negedge aclk);
        do_read("t5_rd40", 32'h40, 32'h01234567, 2'b00, 0);

        // Reset while a read response is pending drops RVALID and clears RDATA
        bus.ARADDR  = 32'h10;
        bus.ARVALID = 1'b1;
        @(negedge aclk);
        bus.ARVALID = 1'b0;
        lat = 1;
        while (!bus.RVALID && lat < 20) begin
            @(negedge aclk);
            lat++;
        end
        check_output("t5_rresp_pending", 32'(bus.RVALID), 32'd1);
        aresetn = 1'b0;
        #1;
        check_output("t5_rst_rvalid", 32'(bus.RVALID), 32'd0);
        check_output("t5_rst_rdata", bus.RDATA, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        do_read("t5_sram_kept", 32'h10, 32'hDEADBEEF, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
